// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Produces the ALU operands, store data and registered control for the EX stage.
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          iStall,
  input  logic          iFlush,
  input  logic          iValid,
  input  logic [DW-1:0] iRsData,
  input  logic [DW-1:0] iRtData,
  input  logic [DW-1:0] iImm,
  input  logic [4:0]    iShamt,
  input  logic [RW-1:0] iRs,
  input  logic [RW-1:0] iRt,
  input  logic [RW-1:0] iRd,
  input  logic          iALUSrcA,
  input  logic          iALUSrcB,
  input  logic [5:0]    iALUFun,
  input  logic          iSign,
  input  logic          iRegWrite,
  input  logic          iExMemRegWrite,
  input  logic [RW-1:0] iExMemRd,
  input  logic [DW-1:0] iExMemData,
  input  logic          iMemWbRegWrite,
  input  logic [RW-1:0] iMemWbRd,
  input  logic [DW-1:0] iMemWbData,
  output logic [DW-1:0] oA,
  output logic [DW-1:0] oB,
  output logic [DW-1:0] oStoreData,
  output logic [5:0]    oALUFun,
  output logic          oSign,
  output logic [RW-1:0] oRd,
  output logic          oRegWrite,
  output logic          oValid
);

  // All-zero encoding is both the reset state and the bubble (ALUFun 0 = ADD).
  typedef struct packed {
    logic          valid;
    logic          regWrite;
    logic [5:0]    aluFun;
    logic          sign;
    logic          aluSrcA;
    logic          aluSrcB;
    logic [4:0]    shamt;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rsData;
    logic [DW-1:0] rtData;
    logic [DW-1:0] imm;
  } stage_t;

  stage_t stage;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      stage <= '0;
    end else if (iFlush) begin
      stage <= '0;
    end else if (!iStall) begin
      stage.valid    <= iValid;
      stage.regWrite <= iRegWrite & iValid;
      stage.aluFun   <= iALUFun;
      stage.sign     <= iSign;
      stage.aluSrcA  <= iALUSrcA;
      stage.aluSrcB  <= iALUSrcB;
      stage.shamt    <= iShamt;
      stage.rs       <= iRs;
      stage.rt       <= iRt;
      stage.rd       <= iRd;
      stage.rsData   <= iRsData;
      stage.rtData   <= iRtData;
      stage.imm      <= iImm;
    end
  end

  // EX/MEM is the younger result, so it is tested first; $0 never forwards.
  logic exMemHitRs, memWbHitRs, exMemHitRt, memWbHitRt;
  logic [DW-1:0] fwdRs, fwdRt;

  assign exMemHitRs = iExMemRegWrite && (iExMemRd == stage.rs) && (stage.rs != '0);
  assign memWbHitRs = iMemWbRegWrite && (iMemWbRd == stage.rs) && (stage.rs != '0);
  assign exMemHitRt = iExMemRegWrite && (iExMemRd == stage.rt) && (stage.rt != '0);
  assign memWbHitRt = iMemWbRegWrite && (iMemWbRd == stage.rt) && (stage.rt != '0);

  assign fwdRs = exMemHitRs ? iExMemData : (memWbHitRs ? iMemWbData : stage.rsData);
  assign fwdRt = exMemHitRt ? iExMemData : (memWbHitRt ? iMemWbData : stage.rtData);

  assign oA         = stage.aluSrcA ? {{(DW-5){1'b0}}, stage.shamt} : fwdRs;
  assign oB         = stage.aluSrcB ? stage.imm : fwdRt;
  assign oStoreData = fwdRt;
  assign oALUFun    = stage.aluFun;
  assign oSign      = stage.sign;
  assign oRd        = stage.rd;
  assign oRegWrite  = stage.regWrite;
  assign oValid     = stage.valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, load, forwarding priority,
// $0 blocking, shift operand select, stall, flush and reset during stall.
module tb_alu_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          iClk = 1'b0;
  logic          iReset, iStall, iFlush, iValid;
  logic [DW-1:0] iRsData, iRtData, iImm;
  logic [4:0]    iShamt;
  logic [RW-1:0] iRs, iRt, iRd;
  logic          iALUSrcA, iALUSrcB;
  logic [5:0]    iALUFun;
  logic          iSign, iRegWrite;
  logic          iExMemRegWrite, iMemWbRegWrite;
  logic [RW-1:0] iExMemRd, iMemWbRd;
  logic [DW-1:0] iExMemData, iMemWbData;
  logic [DW-1:0] oA, oB, oStoreData;
  logic [5:0]    oALUFun;
  logic          oSign, oRegWrite, oValid;
  logic [RW-1:0] oRd;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  alu_operand_stage #(.DW(DW), .RW(RW)) dut (
    .iClk(iClk), .iReset(iReset), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iRsData(iRsData), .iRtData(iRtData), .iImm(iImm), .iShamt(iShamt),
    .iRs(iRs), .iRt(iRt), .iRd(iRd), .iALUSrcA(iALUSrcA), .iALUSrcB(iALUSrcB),
    .iALUFun(iALUFun), .iSign(iSign), .iRegWrite(iRegWrite),
    .iExMemRegWrite(iExMemRegWrite), .iExMemRd(iExMemRd), .iExMemData(iExMemData),
    .iMemWbRegWrite(iMemWbRegWrite), .iMemWbRd(iMemWbRd), .iMemWbData(iMemWbData),
    .oA(oA), .oB(oB), .oStoreData(oStoreData), .oALUFun(oALUFun), .oSign(oSign),
    .oRd(oRd), .oRegWrite(oRegWrite), .oValid(oValid)
  );

  task automatic clearInputs();
    iStall = 0; iFlush = 0; iValid = 0;
    iRsData = '0; iRtData = '0; iImm = '0; iShamt = '0;
    iRs = '0; iRt = '0; iRd = '0; iALUSrcA = 0; iALUSrcB = 0;
    iALUFun = '0; iSign = 0; iRegWrite = 0;
    iExMemRegWrite = 0; iExMemRd = '0; iExMemData = '0;
    iMemWbRegWrite = 0; iMemWbRd = '0; iMemWbData = '0;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic loadPlain(input logic [RW-1:0] rs, input logic [DW-1:0] rsData,
                           input logic [RW-1:0] rt, input logic [DW-1:0] rtData,
                           input logic [RW-1:0] rd, input logic [5:0] fun);
    iValid = 1; iRegWrite = 1; iALUSrcA = 0; iALUSrcB = 0; iSign = 0;
    iRs = rs; iRsData = rsData; iRt = rt; iRtData = rtData; iRd = rd; iALUFun = fun;
    tick();
  endtask

  task automatic test_reset();
    loadPlain(5'd3, 32'h1234, 5'd4, 32'h5678, 5'd7, 6'h22);
    iSign = 1;
    total++;
    if (oValid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", oValid); end
    iReset = 1;
    #1;
    total++;
    if ({oValid, oRegWrite, oSign} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000", {oValid, oRegWrite, oSign});
    end
    total++;
    if (oALUFun !== 6'b000000) begin bad++; $display("FAIL reset_alufun got=%b want=000000", oALUFun); end
    total++;
    if (oRd !== '0) begin bad++; $display("FAIL reset_rd got=%0d want=0", oRd); end
    total++;
    if ({oA, oB, oStoreData} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0/0/0", oA, oB, oStoreData);
    end
    tick();
    iReset = 0;
    clearInputs();
  endtask

  task automatic test_load();
    loadPlain(5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 6'b000000);
    total++;
    if (oA !== 32'd5) begin bad++; $display("FAIL load_a got=%h want=5", oA); end
    total++;
    if (oB !== 32'd7) begin bad++; $display("FAIL load_b got=%h want=7", oB); end
    total++;
    if ({oRegWrite, oValid} !== 2'b11) begin bad++; $display("FAIL load_ctrl got=%b want=11", {oRegWrite, oValid}); end
    total++;
    if (oRd !== 5'd9) begin bad++; $display("FAIL load_rd got=%0d want=9", oRd); end
    // Invalid instruction: regwrite must be gated off even though requested.
    iValid = 0; iRegWrite = 1;
    tick();
    total++;
    if ({oRegWrite, oValid} !== 2'b00) begin bad++; $display("FAIL gate_regwrite got=%b want=00", {oRegWrite, oValid}); end
  endtask

  task automatic test_forward_priority();
    loadPlain(5'd3, 32'h11, 5'd4, 32'h22, 5'd8, 6'h00);
    iExMemRegWrite = 1; iExMemRd = 5'd3; iExMemData = 32'hAA;
    iMemWbRegWrite = 1; iMemWbRd = 5'd3; iMemWbData = 32'hBB;
    #1;
    total++;
    if (oA !== 32'hAA) begin bad++; $display("FAIL fwd_exmem_wins got=%h want=aa", oA); end
    iExMemRegWrite = 0;
    #1;
    total++;
    if (oA !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h want=bb", oA); end
    iMemWbRegWrite = 0;
    #1;
    total++;
    if (oA !== 32'h11) begin bad++; $display("FAIL fwd_none got=%h want=11", oA); end
    // rt path: MEM/WB hit feeds both oB and store data.
    iMemWbRegWrite = 1; iMemWbRd = 5'd4; iMemWbData = 32'hCC;
    #1;
    total++;
    if ({oB, oStoreData} !== {32'hCC, 32'hCC}) begin
      bad++; $display("FAIL fwd_rt got=%h/%h want=cc/cc", oB, oStoreData);
    end
    clearInputs();
  endtask

  task automatic test_zero_reg();
    loadPlain(5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 6'h00);
    iExMemRegWrite = 1; iExMemRd = 5'd0; iExMemData = 32'hFF;
    iMemWbRegWrite = 1; iMemWbRd = 5'd0; iMemWbData = 32'hEE;
    #1;
    total++;
    if (oA !== 32'd0) begin bad++; $display("FAIL zero_reg_a got=%h want=0", oA); end
    total++;
    if (oStoreData !== 32'd0) begin bad++; $display("FAIL zero_reg_rt got=%h want=0", oStoreData); end
    clearInputs();
  endtask

  task automatic test_shift_select();
    iValid = 1; iRegWrite = 1; iALUSrcA = 1; iShamt = 5'd5; iALUFun = 6'b100000;
    iRs = 5'd2; iRsData = 32'h99; iRt = 5'd4; iRtData = 32'h77; iRd = 5'd6;
    tick();
    iExMemRegWrite = 1; iExMemRd = 5'd4; iExMemData = 32'h1;
    #1;
    total++;
    if (oA !== 32'd5) begin bad++; $display("FAIL sll_a got=%h want=5", oA); end
    total++;
    if (oB !== 32'h1) begin bad++; $display("FAIL sll_b got=%h want=1", oB); end
    total++;
    if (oALUFun !== 6'b100000) begin bad++; $display("FAIL sll_fun got=%b want=100000", oALUFun); end
    // Immediate on B; store data still carries the forwarded rt.
    iALUSrcA = 0; iALUSrcB = 1; iImm = 32'hFFFF_FFF0; iExMemRegWrite = 0;
    tick();
    iExMemRegWrite = 1;
    #1;
    total++;
    if ({oB, oStoreData} !== {32'hFFFF_FFF0, 32'h1}) begin
      bad++; $display("FAIL imm_b got=%h/%h want=fffffff0/1", oB, oStoreData);
    end
    clearInputs();
  endtask

  task automatic test_stall_flush();
    iSign = 1;
    loadPlain(5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 6'h21);
    iStall = 1;
    for (int i = 0; i < 3; i++) begin
      iRsData = 32'h100 + i; iRtData = 32'h200 + i; iRd = 5'(10 + i);
      iALUFun = 6'(i); iSign = 0; iValid = 0;
      tick();
      total++;
      if ({oA, oB, oRd, oALUFun, oValid} !== {32'h11, 32'h22, 5'd9, 6'h21, 1'b1}) begin
        bad++; $display("FAIL stall_hold cycle=%0d got=%h/%h/%0d/%h/%b want=11/22/9/21/1",
                        i, oA, oB, oRd, oALUFun, oValid);
      end
    end
    iFlush = 1;
    tick();
    total++;
    if ({oValid, oRegWrite} !== 2'b00) begin bad++; $display("FAIL flush_ctrl got=%b want=00", {oValid, oRegWrite}); end
    total++;
    if ({oA, oB, oRd, oALUFun} !== '0) begin
      bad++; $display("FAIL flush_data got=%h/%h/%0d/%h want=0", oA, oB, oRd, oALUFun);
    end
    clearInputs();
  endtask

  task automatic test_reset_in_stall();
    loadPlain(5'd3, 32'h55, 5'd4, 32'h66, 5'd2, 6'h01);
    iStall = 1;
    iReset = 1;
    #1;
    total++;
    if ({oValid, oA, oRd} !== '0) begin bad++; $display("FAIL reset_stall got=%b/%h/%0d want=0", oValid, oA, oRd); end
    #2;
    iReset = 0;
    iValid = 1; iRegWrite = 1; iRsData = 32'h77; iRs = 5'd5;
    tick();
    total++;
    if ({oValid, oA} !== '0) begin bad++; $display("FAIL hold_bubble got=%b/%h want=0/0", oValid, oA); end
    iStall = 0;
    tick();
    total++;
    if ({oValid, oA} !== {1'b1, 32'h77}) begin bad++; $display("FAIL resume_load got=%b/%h want=1/77", oValid, oA); end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    iReset = 1;
    repeat (2) @(posedge iClk);
    #1;
    iReset = 0;
    test_reset();
    test_load();
    test_forward_priority();
    test_zero_reg();
    test_shift_select();
    test_stall_flush();
    test_reset_in_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
